harmonic_mixer: RTL

//  Downstream of the per-harmonic create_harmonic generators. On each codec

---
 rtl/harmonic_mixer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/harmonic_mixer.sv
// Collects one signed sample per harmonic lane per codec request, sums the
// lanes serially, scales and saturates the result, and strobes it out.
module harmonic_mixer #(
  parameter int N_HARM         = 3,
  parameter int GAIN_SHIFT     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  generate_next_sample,
  input  logic [N_HARM-1:0]     harm_en,
  input  logic [16*N_HARM-1:0]  harm_in,
  input  logic [N_HARM-1:0]     harm_ready,
  output logic [15:0]           mixed_out,
  output logic                  mixed_ready,
  output logic                  timeout_err,
  output logic                  overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW = $clog2(N_HARM + 1);
  localparam int AW = 20;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUM, S_OUT} state_e;

  state_e                     state_q, state_d;
  logic [N_HARM-1:0]          got_q, got_d;
  logic [N_HARM-1:0][15:0]    cap_q, cap_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic [15:0]                mixed_out_q, mixed_out_d;
  logic                       mixed_ready_q, mixed_ready_d;
  logic                       timeout_err_q, timeout_err_d;
  logic                       overrun_q, overrun_d;

  logic [N_HARM-1:0][15:0]    lane_in;
  logic [N_HARM-1:0]          newcap;
  logic                       all_got;
  logic [15:0]                sel_cap;
  logic signed [AW-1:0]       scaled;
  logic [15:0]                sat_val;

  // Flat bus and packed lane array share the same bit layout.
  assign lane_in = harm_in;
  assign newcap  = harm_ready & ~got_q;
  assign all_got = &(got_q | newcap);

  always_comb begin
    sel_cap = '0;
    for (int k = 0; k < N_HARM; k++)
      if (idx_q == IW'(k)) sel_cap = cap_q[k];
  end

  always_comb begin
    scaled = acc_q >>> GAIN_SHIFT;
    if (scaled > 20'sd32767)        sat_val = 16'h7fff;
    else if (scaled < -20'sd32768)  sat_val = 16'h8000;
    else                            sat_val = scaled[15:0];
  end

  always_comb begin
    state_d       = state_q;
    got_d         = got_q;
    cap_d         = cap_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    mixed_out_d   = mixed_out_q;
    mixed_ready_d = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (generate_next_sample) begin
          state_d = S_COLLECT;
          got_d   = ~harm_en;
          cap_d   = '0;
          timer_d = '0;
        end
      end
      S_COLLECT: begin
        overrun_d = generate_next_sample;
        for (int k = 0; k < N_HARM; k++)
          if (newcap[k]) cap_d[k] = lane_in[k];
        got_d   = got_q | newcap;
        timer_d = timer_q + 1'b1;
        if (all_got) begin
          state_d = S_SUM;
          acc_d   = '0;
          idx_d   = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Missing lanes keep their cleared capture and add zero.
          state_d       = S_SUM;
          acc_d         = '0;
          idx_d         = '0;
          timeout_err_d = 1'b1;
        end
      end
      S_SUM: begin
        overrun_d = generate_next_sample;
        if (idx_q == IW'(N_HARM)) begin
          state_d       = S_OUT;
          mixed_out_d   = play_enable ? sat_val : 16'h0000;
          mixed_ready_d = 1'b1;
        end else begin
          acc_d = acc_q + AW'($signed(sel_cap));
          idx_d = idx_q + 1'b1;
        end
      end
      S_OUT: begin
        overrun_d = generate_next_sample;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      got_q         <= '0;
      cap_q         <= '0;
      timer_q       <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      mixed_out_q   <= '0;
      mixed_ready_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      got_q         <= got_d;
      cap_q         <= cap_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      mixed_out_q   <= mixed_out_d;
      mixed_ready_q <= mixed_ready_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign mixed_out   = mixed_out_q;
  assign mixed_ready = mixed_ready_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule
